// File: rtl/mult_arbiter_pkg.sv
// Shared definitions for the multiplier arbiter: FSM encoding, requester
// indices and the default watchdog limit.
package mult_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } arb_state_t;

    localparam int unsigned REQ0 = 0;
    localparam int unsigned REQ1 = 1;

    localparam int unsigned DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/mult_arbiter_rr_pick2.sv
// Combinational two-input round-robin picker: a lone request wins outright,
// a tie goes to the requester named by pointer. Output is one-hot or zero.
module rr_pick2
    import mult_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       pointer,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req[REQ0] && req[REQ1]) begin
            grant = pointer ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin owner of the shared sequential multiplier with a WAIT watchdog.
// Define ARB_STATS_EN to build the per-requester completion counters cnt0/cnt1.
module mult_arbiter
    import mult_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic [1:0]       grant,
    output logic             mul_start,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    output logic             mul_rst,
    input  logic             mul_done,
    input  logic [WIDTH-1:0] mul_result,
    input  logic             mul_ov,
    output logic [1:0]       rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_ov,
    output logic             rsp_err,
    output logic             busy,
    output logic [7:0]       cnt0,
    output logic [7:0]       cnt1
);

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    arb_state_t state, next_state;
    logic       pointer;
    logic [1:0] pick;
    logic [7:0] wait_cnt;
    logic       wait_expired;

    rr_pick2 u_pick (
        .req     (req),
        .pointer (pointer),
        .grant   (pick)
    );

    assign wait_expired = (wait_cnt == LAST_WAIT);
    assign busy         = (state != IDLE);

    always_ff @(posedge clock) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        mul_start  = 1'b0;
        mul_rst    = 1'b0;
        rsp_valid  = '0;
        case (state)
            IDLE: begin
                if (|req) next_state = START;
            end
            START: begin
                mul_start  = 1'b1;
                next_state = WAIT;
            end
            WAIT: begin
                // A done arriving on the expiry cycle takes precedence over the abort
                if (mul_done) begin
                    next_state = RESP;
                end else if (wait_expired) begin
                    mul_rst    = 1'b1;
                    next_state = RESP;
                end
            end
            RESP: begin
                rsp_valid  = grant;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            grant    <= '0;
            pointer  <= 1'b0;
            mul_a    <= '0;
            mul_b    <= '0;
            wait_cnt <= '0;
            rsp_data <= '0;
            rsp_ov   <= 1'b0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant <= pick;
                        mul_a <= pick[REQ1] ? a1 : a0;
                        mul_b <= pick[REQ1] ? b1 : b0;
                    end
                end
                START: begin
                    wait_cnt <= '0;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 8'd1;
                    if (mul_done) begin
                        rsp_data <= mul_result;
                        rsp_ov   <= mul_ov;
                        rsp_err  <= 1'b0;
                    end else if (wait_expired) begin
                        rsp_data <= '0;
                        rsp_ov   <= 1'b0;
                        rsp_err  <= 1'b1;
                    end
                end
                RESP: begin
                    grant   <= '0;
                    pointer <= grant[REQ0];
                end
                default: ;
            endcase
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clock) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (state == RESP && !rsp_err) begin
            if (grant[REQ0] && cnt0 != 8'hFF) cnt0 <= cnt0 + 8'd1;
            if (grant[REQ1] && cnt1 != 8'hFF) cnt1 <= cnt1 + 8'd1;
        end
    end
`else
    assign cnt0 = '0;
    assign cnt1 = '0;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: directed vector table, hand-written
// reset sequences and randomized traffic against a transaction-level model.
module tb_mult_arbiter;

    localparam int unsigned TO = 16;

    logic       clock = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [7:0] a0, b0, a1, b1;
    logic [1:0] grant;
    logic       mul_start, mul_rst, mul_done, mul_ov;
    logic [7:0] mul_a, mul_b, mul_result;
    logic [1:0] rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_ov, rsp_err, busy;
    logic [7:0] cnt0, cnt1;

    int unsigned total  = 0;
    int unsigned passed = 0;

    // Model state: who wins the next tie, and successful completions per requester
    int          mptr;
    int unsigned mcnt [2];

    typedef struct {
        logic [1:0] r;
        logic [7:0] x0, y0, x1, y1;
        int         lat;
        bit         spur;
        int         win;
        logic [7:0] data;
        logic       ov;
        logic       err;
    } vec_t;

    vec_t tbl [8];

    mult_arbiter #(.WIDTH(8), .TIMEOUT(TO)) dut (
        .clock      (clock),
        .rst        (rst),
        .req        (req),
        .a0         (a0),
        .b0         (b0),
        .a1         (a1),
        .b1         (b1),
        .grant      (grant),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_rst    (mul_rst),
        .mul_done   (mul_done),
        .mul_result (mul_result),
        .mul_ov     (mul_ov),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_ov     (rsp_ov),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [1:0] onehot(input int w);
        return (w == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic chk_cnt(input string tag);
`ifdef ARB_STATS_EN
        chk({tag, " cnt0"}, cnt0, mcnt[0]);
        chk({tag, " cnt1"}, cnt1, mcnt[1]);
`else
        chk({tag, " cnt0"}, cnt0, 0);
        chk({tag, " cnt1"}, cnt1, 0);
`endif
    endtask

    // Entered just after the negedge of an IDLE cycle; leaves at the same point
    // of the IDLE cycle that follows the response. lat==0 means no mul_done.
    task automatic do_op(input logic [1:0] r, input logic [7:0] x0, y0, x1, y1,
                         input int lat, input bit drop, input bit spur,
                         input int win, input logic [7:0] edata,
                         input logic eov, input logic eerr);
        logic [7:0]  ea, eb;
        logic [15:0] prod;
        bit          fin;
        ea   = (win == 1) ? x1 : x0;
        eb   = (win == 1) ? y1 : y0;
        prod = {8'd0, ea} * {8'd0, eb};
        req = r; a0 = x0; b0 = y0; a1 = x1; b1 = y1; mul_done = 1'b0;

        @(negedge clock);
        mul_done = spur;
        if (drop) req = 2'b00;
        a0 = 8'($urandom); b0 = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
        #1;
        chk("start grant", grant, onehot(win));
        chk("start mul_start", mul_start, 1'b1);
        chk("start mul_a", mul_a, ea);
        chk("start mul_b", mul_b, eb);
        chk("start busy", busy, 1'b1);
        chk("start rsp_valid", rsp_valid, 2'b00);

        fin = 1'b0;
        for (int k = 1; k <= int'(TO) && !fin; k++) begin
            @(negedge clock);
            mul_done   = (k == lat);
            mul_result = (k == lat) ? prod[7:0] : 8'($urandom);
            mul_ov     = (k == lat) ? (prod > 16'd255) : 1'($urandom);
            #1;
            chk("wait mul_start", mul_start, 1'b0);
            chk("wait mul_rst", mul_rst, (k == int'(TO)) && (lat != k));
            chk("wait rsp_valid", rsp_valid, 2'b00);
            chk("wait grant", grant, onehot(win));
            if (k == lat || k == int'(TO)) fin = 1'b1;
        end

        @(negedge clock);
        mul_done   = spur;
        mul_result = 8'($urandom);
        #1;
        chk("resp rsp_valid", rsp_valid, onehot(win));
        chk("resp rsp_data", rsp_data, edata);
        chk("resp rsp_ov", rsp_ov, eov);
        chk("resp rsp_err", rsp_err, eerr);
        chk("resp mul_rst", mul_rst, 1'b0);
        chk("resp mul_a hold", mul_a, ea);
        chk("resp mul_b hold", mul_b, eb);
        chk("resp busy", busy, 1'b1);

        mptr = (win == 0) ? 1 : 0;
        if (!eerr && mcnt[win] < 255) mcnt[win]++;

        @(negedge clock);
        mul_done = 1'b0;
        req      = 2'b00;
        #1;
        chk("idle grant", grant, 2'b00);
        chk("idle busy", busy, 1'b0);
        chk("idle rsp_valid", rsp_valid, 2'b00);
        chk("idle rsp_data hold", rsp_data, edata);
        chk("idle rsp_err hold", rsp_err, eerr);
        chk_cnt("idle");
    endtask

    initial begin
        logic [1:0]  r;
        logic [7:0]  x0, y0, x1, y1, ea, eb;
        logic [15:0] prod;
        int          lat, win, rv;

        tbl[0] = '{2'b11, 8'd3,  8'd4,   8'd20,  8'd20,  4,  1'b0, 0, 8'd12,  1'b0, 1'b0};
        tbl[1] = '{2'b11, 8'd3,  8'd4,   8'd20,  8'd20,  2,  1'b0, 1, 8'd144, 1'b1, 1'b0};
        tbl[2] = '{2'b11, 8'd3,  8'd4,   8'd20,  8'd20,  1,  1'b1, 0, 8'd12,  1'b0, 1'b0};
        tbl[3] = '{2'b01, 8'd12, 8'd10,  8'd0,   8'd0,   5,  1'b0, 0, 8'd120, 1'b0, 1'b0};
        tbl[4] = '{2'b10, 8'd0,  8'd0,   8'd255, 8'd255, 16, 1'b1, 1, 8'd1,   1'b1, 1'b0};
        tbl[5] = '{2'b10, 8'd0,  8'd0,   8'd7,   8'd9,   0,  1'b0, 1, 8'd0,   1'b0, 1'b1};
        tbl[6] = '{2'b01, 8'd0,  8'd200, 8'd0,   8'd0,   1,  1'b0, 0, 8'd0,   1'b0, 1'b0};
        tbl[7] = '{2'b11, 8'd16, 8'd16,  8'd2,   8'd3,   3,  1'b0, 1, 8'd6,   1'b0, 1'b0};

        rst = 1'b1; req = 2'b00; mul_done = 1'b0; mul_result = '0; mul_ov = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        mptr = 0; mcnt[0] = 0; mcnt[1] = 0;

        @(negedge clock);
        @(negedge clock);
        rst = 1'b0;
        #1;
        chk("reset grant", grant, 2'b00);
        chk("reset busy", busy, 1'b0);
        chk("reset rsp_valid", rsp_valid, 2'b00);
        chk("reset mul_rst", mul_rst, 1'b0);
        chk("reset rsp_data", rsp_data, 8'd0);
        chk("reset rsp_err", rsp_err, 1'b0);
        chk_cnt("reset");
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #1;
            chk("reset idle mul_start", mul_start, 1'b0);
            chk("reset idle busy", busy, 1'b0);
        end

        foreach (tbl[i]) begin
            do_op(tbl[i].r, tbl[i].x0, tbl[i].y0, tbl[i].x1, tbl[i].y1, tbl[i].lat,
                  1'b0, tbl[i].spur, tbl[i].win, tbl[i].data, tbl[i].ov, tbl[i].err);
        end

        for (int i = 0; i < 600; i++) begin
            rv = int'($urandom_range(0, 9));
            r  = (rv < 6) ? 2'b01 : (rv < 8) ? 2'b11 : 2'b10;
            x0 = 8'($urandom); y0 = 8'($urandom); x1 = 8'($urandom); y1 = 8'($urandom);
            lat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TO));
            win = (r == 2'b11) ? mptr : (r == 2'b10) ? 1 : 0;
            ea   = (win == 1) ? x1 : x0;
            eb   = (win == 1) ? y1 : y0;
            prod = {8'd0, ea} * {8'd0, eb};
            do_op(r, x0, y0, x1, y1, lat, ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 2) == 0), win,
                  (lat == 0) ? 8'd0 : prod[7:0],
                  (lat == 0) ? 1'b0 : (prod > 16'd255),
                  (lat == 0));
        end

        // Leave the pointer at 1 so the post-reset tie proves it was cleared.
        do_op(2'b01, 8'd2, 8'd2, 8'd0, 8'd0, 2, 1'b0, 1'b0, 0, 8'd4, 1'b0, 1'b0);

        req = 2'b01; a0 = 8'd5; b0 = 8'd6;
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        rst = 1'b1; req = 2'b00; mul_done = 1'b1; mul_result = 8'd77; mul_ov = 1'b1;
        @(negedge clock);
        rst = 1'b0; mul_done = 1'b0;
        mptr = 0; mcnt[0] = 0; mcnt[1] = 0;
        #1;
        chk("midrst grant", grant, 2'b00);
        chk("midrst busy", busy, 1'b0);
        chk("midrst rsp_valid", rsp_valid, 2'b00);
        chk("midrst rsp_data", rsp_data, 8'd0);
        chk("midrst rsp_ov", rsp_ov, 1'b0);
        chk("midrst rsp_err", rsp_err, 1'b0);
        chk("midrst mul_a", mul_a, 8'd0);
        chk("midrst mul_b", mul_b, 8'd0);
        chk_cnt("midrst");
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            #1;
            chk("midrst quiet rsp_valid", rsp_valid, 2'b00);
            chk("midrst quiet mul_start", mul_start, 1'b0);
        end

        do_op(2'b11, 8'd9, 8'd9, 8'd1, 8'd1, 2, 1'b0, 1'b0, 0, 8'd81, 1'b0, 1'b0);
        do_op(2'b11, 8'd9, 8'd9, 8'd1, 8'd1, 1, 1'b0, 1'b0, 1, 8'd1,  1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
